// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV32E decode with illegal detection, flush, backpressure and a DEPTH-entry queue.
// Define DECODE_STATS_EN to add the stat_decoded/stat_illegal push counters.
package rv32i;
    typedef enum logic [6:0] {
        OP_LOAD = 7'h03, OP_FENCE = 7'h0F, OP_OPIMM = 7'h13, OP_AUIPC = 7'h17,
        OP_STORE = 7'h23, OP_OP = 7'h33, OP_LUI = 7'h37, OP_BRANCH = 7'h63,
        OP_JALR = 7'h67, OP_JAL = 7'h6F, OP_SYSTEM = 7'h73
    } opcode_e;
    typedef enum logic [5:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_JAL, ALU_JALR, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
        ALU_BGEU, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW
    } alu_op_e;
    typedef enum logic [1:0] {IN_NONE, IN_REG, IN_IMM, IN_PC} alu_input_type_e;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC} wb_from_e;
    typedef enum logic {REG_WD, REG_WE} reg_we_e;
    typedef enum logic {MEM_LOAD, MEM_STORE} mem_op_e;
endpackage

module decode_stage
    import rv32i::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [31:0]           out_imm,
    output alu_op_e               out_alu_op,
    output alu_input_type_e       out_alu_input1_type,
    output alu_input_type_e       out_alu_input2_type,
    output wb_from_e              out_wb_from,
    output reg_we_e               out_r_we,
    output mem_op_e               out_mem_op,
    output logic                  out_illegal
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]           stat_decoded,
    output logic [31:0]           stat_illegal
`endif
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [4:0]          rs1, rs2, rd;
        logic [31:0]         imm;
        alu_op_e             alu_op;
        alu_input_type_e     in1, in2;
        wb_from_e            wb;
        reg_we_e             we;
        mem_op_e             mop;
        logic                illegal;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         d, head;
    logic [PW-1:0]  wptr, rptr;
    logic [CW-1:0]  count, cnt_next;
    logic           push, pop, use1, use2, used, bad;
    logic [2:0]     f3;
    logic [6:0]     f7;
    logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;

    function automatic alu_op_e alu_of(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic bad_reg(input logic [4:0] r);
        return 32'(r) >= NUM_REGS;
    endfunction

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        d = '0;
        d.pc = in_pc;
        use1 = 1'b0;
        use2 = 1'b0;
        used = 1'b0;
        bad = 1'b0;
        case (in_instr[6:0])
            OP_LUI: begin
                used = 1'b1; d.imm = imm_u; d.alu_op = ALU_ADD; d.in1 = IN_IMM; d.we = REG_WE; d.wb = WB_ALU;
            end
            OP_AUIPC: begin
                used = 1'b1; d.imm = imm_u; d.alu_op = ALU_ADD; d.in1 = IN_PC; d.in2 = IN_IMM;
                d.we = REG_WE; d.wb = WB_ALU;
            end
            OP_JAL: begin
                used = 1'b1; d.imm = imm_j; d.alu_op = ALU_JAL; d.in1 = IN_PC; d.in2 = IN_IMM;
                d.we = REG_WE; d.wb = WB_PC;
            end
            OP_JALR: begin
                used = 1'b1; use1 = 1'b1; d.imm = imm_i; d.alu_op = ALU_JALR; d.in1 = IN_REG; d.in2 = IN_IMM;
                d.we = REG_WE; d.wb = WB_PC;
            end
            OP_BRANCH: begin
                use1 = 1'b1; use2 = 1'b1; d.imm = imm_b; d.in1 = IN_REG; d.in2 = IN_REG;
                d.alu_op = f3 == 3'd0 ? ALU_BEQ : f3 == 3'd1 ? ALU_BNE : f3 == 3'd4 ? ALU_BLT :
                           f3 == 3'd5 ? ALU_BGE : f3 == 3'd6 ? ALU_BLTU : ALU_BGEU;
                bad = f3[2:1] == 2'b01;
            end
            OP_LOAD: begin
                used = 1'b1; use1 = 1'b1; d.imm = imm_i; d.in1 = IN_REG; d.in2 = IN_IMM; d.we = REG_WE; d.wb = WB_MEM;
                d.alu_op = f3 == 3'd0 ? ALU_LB : f3 == 3'd1 ? ALU_LH : f3 == 3'd2 ? ALU_LW :
                           f3 == 3'd4 ? ALU_LBU : ALU_LHU;
                bad = f3 == 3'd3 || f3[2:1] == 2'b11;
            end
            OP_STORE: begin
                use1 = 1'b1; use2 = 1'b1; d.imm = imm_s; d.in1 = IN_REG; d.in2 = IN_IMM; d.mop = MEM_STORE;
                d.alu_op = f3 == 3'd0 ? ALU_SB : f3 == 3'd1 ? ALU_SH : ALU_SW;
                bad = f3 >= 3'd3;
            end
            OP_OPIMM: begin
                // shifts carry a zero-extended shamt and use imm[11:5] as funct7
                used = 1'b1; use1 = 1'b1; d.in1 = IN_REG; d.in2 = IN_IMM; d.we = REG_WE; d.wb = WB_ALU;
                d.imm = f3[1:0] == 2'b01 ? {27'b0, in_instr[24:20]} : imm_i;
                d.alu_op = alu_of(f3, f3 == 3'd5 && f7[5]);
                bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            OP_OP: begin
                used = 1'b1; use1 = 1'b1; use2 = 1'b1; d.in1 = IN_REG; d.in2 = IN_REG; d.we = REG_WE; d.wb = WB_ALU;
                d.alu_op = alu_of(f3, f7[5]);
                bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            OP_FENCE, OP_SYSTEM: d.imm = imm_i;
            default: bad = 1'b1;
        endcase
        d.rs1 = use1 ? in_instr[19:15] : 5'd0;
        d.rs2 = use2 ? in_instr[24:20] : 5'd0;
        d.rd = used ? in_instr[11:7] : 5'd0;
        bad = bad | (use1 && bad_reg(in_instr[19:15])) | (use2 && bad_reg(in_instr[24:20])) |
              (used && bad_reg(in_instr[11:7]));
        if (bad) begin
            d.illegal = 1'b1; d.alu_op = ALU_NOP; d.rd = 5'd0; d.we = REG_WD; d.mop = MEM_LOAD; d.wb = WB_NONE;
        end
    end

    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready;
    assign cnt_next = flush ? '0 : count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wptr <= '0;
            rptr <= '0;
            in_ready <= 1'b0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            count <= cnt_next;
            in_ready <= 32'(cnt_next) < DEPTH;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) begin
                    mem[wptr] <= d;
                    wptr <= inc(wptr);
                end
                if (pop) rptr <= inc(rptr);
            end
        end
    end

`ifdef DECODE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_decoded <= '0;
            stat_illegal <= '0;
        end else if (push) begin
            stat_decoded <= stat_decoded + 32'd1;
            stat_illegal <= stat_illegal + 32'(d.illegal);
        end
    end
`endif

    assign head                = mem[rptr];
    assign out_valid           = count != '0;
    assign out_pc              = head.pc;
    assign out_rs1             = head.rs1;
    assign out_rs2             = head.rs2;
    assign out_rd              = head.rd;
    assign out_imm             = head.imm;
    assign out_alu_op          = head.alu_op;
    assign out_alu_input1_type = head.in1;
    assign out_alu_input2_type = head.in2;
    assign out_wb_from         = head.wb;
    assign out_r_we            = head.we;
    assign out_mem_op          = head.mop;
    assign out_illegal         = head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized scoreboard bench for decode_stage against a rule-level reference decoder.
module tb_decode_stage;
    import rv32i::*;
    localparam int NREGS = 32;
    localparam int DEPTH = 2;

    logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_instr = 0, in_pc = 0;
    logic in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0] out_rs1, out_rs2, out_rd;
    alu_op_e out_alu_op;
    alu_input_type_e out_alu_input1_type, out_alu_input2_type;
    wb_from_e out_wb_from;
    reg_we_e out_r_we;
    mem_op_e out_mem_op;
`ifdef DECODE_STATS_EN
    logic [31:0] stat_decoded, stat_illegal;
    logic [31:0] m_dec = 0, m_ill = 0;
`endif

    always #5 clk = ~clk;

    decode_stage #(.NUM_REGS(NREGS), .DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_alu_input1_type(out_alu_input1_type),
        .out_alu_input2_type(out_alu_input2_type), .out_wb_from(out_wb_from), .out_r_we(out_r_we),
        .out_mem_op(out_mem_op), .out_illegal(out_illegal)
`ifdef DECODE_STATS_EN
        , .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
`endif
    );

    typedef struct packed {
        logic [31:0] pc, imm;
        logic [4:0] rs1, rs2, rd;
        alu_op_e alu;
        alu_input_type_e a, b;
        wb_from_e wb;
        reg_we_e we;
        mem_op_e mem;
        logic ill;
    } exp_t;

    exp_t sbq[$];
    exp_t h;
    int n_vec = 0, n_bad = 0;
    bit rst_last = 1;

    // ALU_NOP in these tables marks a reserved funct3
    alu_op_e br_t [8] = '{ALU_BEQ, ALU_BNE, ALU_NOP, ALU_NOP, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
    alu_op_e ld_t [8] = '{ALU_LB, ALU_LH, ALU_LW, ALU_NOP, ALU_LBU, ALU_LHU, ALU_NOP, ALU_NOP};
    alu_op_e st_t [8] = '{ALU_SB, ALU_SH, ALU_SW, ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP};
    alu_op_e ar_t [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit u1, u2, ud, sh;
        logic [31:0] ii, si, bi, ui, ji;
        f3 = w[14:12];
        f7 = w[31:25];
        u1 = 0; u2 = 0; ud = 0;
        ii = 32'($signed(w[31:20]));
        si = 32'($signed({w[31:25], w[11:7]}));
        bi = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        ui = {w[31:12], 12'h000};
        ji = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        e = '0;
        e.pc = pc;
        case (w[6:0])
            7'h37: begin ud = 1; e.imm = ui; e.alu = ALU_ADD; e.a = IN_IMM; e.we = REG_WE; e.wb = WB_ALU; end
            7'h17: begin ud = 1; e.imm = ui; e.alu = ALU_ADD; e.a = IN_PC; e.b = IN_IMM; e.we = REG_WE; e.wb = WB_ALU; end
            7'h6F: begin ud = 1; e.imm = ji; e.alu = ALU_JAL; e.a = IN_PC; e.b = IN_IMM; e.we = REG_WE; e.wb = WB_PC; end
            7'h67: begin ud = 1; u1 = 1; e.imm = ii; e.alu = ALU_JALR; e.a = IN_REG; e.b = IN_IMM; e.we = REG_WE; e.wb = WB_PC; end
            7'h63: begin u1 = 1; u2 = 1; e.imm = bi; e.alu = br_t[f3]; e.a = IN_REG; e.b = IN_REG; e.ill = e.alu == ALU_NOP; end
            7'h03: begin
                ud = 1; u1 = 1; e.imm = ii; e.alu = ld_t[f3]; e.a = IN_REG; e.b = IN_IMM;
                e.we = REG_WE; e.wb = WB_MEM; e.ill = e.alu == ALU_NOP;
            end
            7'h23: begin
                u1 = 1; u2 = 1; e.imm = si; e.alu = st_t[f3]; e.a = IN_REG; e.b = IN_IMM;
                e.mem = MEM_STORE; e.ill = e.alu == ALU_NOP;
            end
            7'h13: begin
                ud = 1; u1 = 1; e.a = IN_REG; e.b = IN_IMM; e.we = REG_WE; e.wb = WB_ALU;
                sh = f3 == 3'd1 || f3 == 3'd5;
                e.imm = sh ? 32'(w[24:20]) : ii;
                e.alu = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : ar_t[f3];
                e.ill = sh && !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
            end
            7'h33: begin
                ud = 1; u1 = 1; u2 = 1; e.a = IN_REG; e.b = IN_REG; e.we = REG_WE; e.wb = WB_ALU;
                e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                e.alu = f7 == 7'h20 ? (f3 == 3'd0 ? ALU_SUB : ALU_SRA) : ar_t[f3];
            end
            7'h0F, 7'h73: e.imm = ii;
            default: e.ill = 1;
        endcase
        e.rd = ud ? w[11:7] : 5'd0;
        e.rs1 = u1 ? w[19:15] : 5'd0;
        e.rs2 = u2 ? w[24:20] : 5'd0;
        if ((ud && w[11:7] >= NREGS) || (u1 && w[19:15] >= NREGS) || (u2 && w[24:20] >= NREGS)) e.ill = 1;
        if (e.ill) begin
            e.alu = ALU_NOP; e.rd = 0; e.we = REG_WD; e.mem = MEM_LOAD; e.wb = WB_NONE;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = ops[k];
        if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
            w[31:25] = $urandom_range(0, 1) != 0 ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic step(input bit v, input logic [31:0] w, input logic [31:0] pc, input bit rdy,
                        input bit fl, input bit rs, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl; reset = rs;
        acc = v && in_ready && !fl && !rs;
        e = ref_decode(w, pc);
        @(posedge clk);
        rst_last = rs;
        if (rs || fl) sbq.delete();
        if (acc) sbq.push_back(e);
`ifdef DECODE_STATS_EN
        if (rs) begin
            m_dec = 0; m_ill = 0;
        end else if (acc) begin
            m_dec++; m_ill += 32'(e.ill);
        end
`endif
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc, input bit rdy);
        bit acc = 0;
        for (int i = 0; i < 20 && !acc; i++) step(1, w, pc, rdy, 0, 0, acc);
        if (!acc) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: pc %0h not accepted within 20 cycles", pc);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        bit acc;
        repeat (n) step(0, 0, 0, rdy, 0, 0, acc);
    endtask

    // monitor: checks handshake state every cycle, compares and retires the head on a pop
    initial forever begin
        @(negedge clk);
        #1;
        chk("out_valid", out_valid, sbq.size() != 0);
        chk("in_ready", in_ready, !rst_last && sbq.size() < DEPTH);
        if (rst_last) begin
            chk("rst_pc", out_pc, 0); chk("rst_imm", out_imm, 0); chk("rst_rd", out_rd, 0);
            chk("rst_alu", out_alu_op, 0); chk("rst_illegal", out_illegal, 0);
        end
`ifdef DECODE_STATS_EN
        chk("stat_decoded", stat_decoded, m_dec);
        chk("stat_illegal", stat_illegal, m_ill);
`endif
        if (out_valid && sbq.size() != 0) begin
            h = sbq[0];
            chk("illegal", out_illegal, h.ill);
            chk("pc", out_pc, h.pc);
            chk("alu_op", out_alu_op, h.alu);
            chk("rd", out_rd, h.rd);
            chk("r_we", out_r_we, h.we);
            chk("mem_op", out_mem_op, h.mem);
            chk("wb_from", out_wb_from, h.wb);
            if (!h.ill) begin
                chk("rs1", out_rs1, h.rs1);
                chk("rs2", out_rs2, h.rs2);
                chk("imm", out_imm, h.imm);
                chk("in1", out_alu_input1_type, h.a);
                chk("in2", out_alu_input2_type, h.b);
            end
            if (out_ready) void'(sbq.pop_front());
        end
    end

    initial begin
        bit acc;
        repeat (2) step(0, 0, 0, 0, 0, 1, acc);
        idle(1, 0);
        send(32'h00500093, 32'h0, 1);
        idle(2, 1);
        send(32'h0020A423, 32'h4, 1);
        idle(2, 1);
        send(32'h00500093, 32'h0, 0);
        send(32'h0020A423, 32'h4, 0);
        step(1, 32'h00100113, 32'h8, 0, 0, 0, acc);
        chk("bp_third_held", acc, 0);
        send(32'h00100113, 32'h8, 1);
        idle(3, 1);
        send(32'hFFFFFFFF, 32'h10, 1);
        send(32'h021080B3, 32'h14, 1);
        send(32'h011080B3, 32'h18, 1);
        idle(3, 1);
        send(32'h00500093, 32'h100, 0);
        send(32'h00100113, 32'h104, 0);
        step(1, 32'h0020A423, 32'h108, 0, 1, 0, acc);
        idle(2, 1);
        send(32'h00500093, 32'h200, 0);
        step(1, 32'h00100113, 32'h204, 0, 1, 0, acc);
        idle(3, 1);
        send(32'h00500093, 32'h300, 0);
        step(1, 32'h00100113, 32'h304, 0, 0, 1, acc);
        idle(3, 1);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, gen(), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0, acc);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1, 1);
        if (sbq.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: %0d entries still expected", sbq.size());
        end
        idle(2, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
